// File: rtl/hex_display_ctrl.sv
// Registered seven-segment controller: shadow-latched hex value, leading-zero
// blanking and per-digit blinking on a programmable half-period.
module hex_display_ctrl #(
    parameter int unsigned DIGITS    = 6,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic                  blank_lz,
    input  logic                  blink_en,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  blink_phase
);

    localparam int unsigned CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);
    localparam logic [6:0] SEG_DARK = 7'h7F;

    logic [4*DIGITS-1:0] shadow;
    logic [CNT_W-1:0]    cnt;
    logic [DIGITS-1:0]   lz_blank;
    logic [DIGITS-1:0]   blink_blank;
    logic [7*DIGITS-1:0] seg_next;
    logic                zeros_above;

    // Active-low hex glyphs, bit 0 = segment a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h40;
            4'h1: pat = 7'h79;
            4'h2: pat = 7'h24;
            4'h3: pat = 7'h30;
            4'h4: pat = 7'h19;
            4'h5: pat = 7'h12;
            4'h6: pat = 7'h02;
            4'h7: pat = 7'h78;
            4'h8: pat = 7'h00;
            4'h9: pat = 7'h18;
            4'hA: pat = 7'h08;
            4'hB: pat = 7'h03;
            4'hC: pat = 7'h46;
            4'hD: pat = 7'h21;
            4'hE: pat = 7'h06;
            default: pat = 7'h0E;
        endcase
        return pat;
    endfunction

    // A digit is a leading zero when it and every digit above it are zero;
    // digit 0 always stays lit so a zero value still shows one "0".
    always_comb begin
        lz_blank    = '0;
        zeros_above = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            zeros_above = zeros_above && (shadow[4*k +: 4] == 4'h0);
            if (k != 0) begin
                lz_blank[k] = blank_lz && zeros_above;
            end
        end
    end

    assign blink_blank = (blink_en && blink_phase) ? blink_mask : '0;

    always_comb begin
        seg_next = '0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            seg_next[7*k +: 7] = (lz_blank[k] || blink_blank[k]) ? SEG_DARK
                                                                 : hex_to_seg(shadow[4*k +: 4]);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            shadow      <= '0;
            cnt         <= '0;
            blink_phase <= 1'b0;
            seg         <= '1;
        end else begin
            if (load) begin
                shadow <= data;
            end
            if (!blink_en) begin
                cnt         <= '0;
                blink_phase <= 1'b0;
            end else if (cnt == CNT_MAX) begin
                cnt         <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench: three display widths (6, 1, 8 digits) share one stimulus
// stream; a reference model predicts each edge, a monitor checks at negedge.
module tb_hex_display_ctrl;

    localparam int unsigned DIV = 4;
    localparam int NCFG = 3;

    logic        clk;
    logic        resetn;
    logic        load;
    logic [31:0] data;
    logic        blank_lz;
    logic        blink_en;
    logic [7:0]  blink_mask;

    logic [41:0] seg6;
    logic [6:0]  seg1;
    logic [55:0] seg8;
    logic        ph6, ph1, ph8;
    logic [55:0] seg_all [NCFG];
    logic        ph_all  [NCFG];

    int checks = 0;
    int errors = 0;

    logic [56:0] exp_q [NCFG][$];
    logic [31:0] m_shadow [NCFG];
    bit          m_phase;
    int          m_run;

    hex_display_ctrl #(.DIGITS(6), .BLINK_DIV(DIV)) u6 (
        .CLOCK_50(clk), .resetn(resetn), .load(load), .data(data[23:0]),
        .blank_lz(blank_lz), .blink_en(blink_en), .blink_mask(blink_mask[5:0]),
        .seg(seg6), .blink_phase(ph6));
    hex_display_ctrl #(.DIGITS(1), .BLINK_DIV(DIV)) u1 (
        .CLOCK_50(clk), .resetn(resetn), .load(load), .data(data[3:0]),
        .blank_lz(blank_lz), .blink_en(blink_en), .blink_mask(blink_mask[0:0]),
        .seg(seg1), .blink_phase(ph1));
    hex_display_ctrl #(.DIGITS(8), .BLINK_DIV(DIV)) u8 (
        .CLOCK_50(clk), .resetn(resetn), .load(load), .data(data),
        .blank_lz(blank_lz), .blink_en(blink_en), .blink_mask(blink_mask),
        .seg(seg8), .blink_phase(ph8));

    assign seg_all[0] = {14'b0, seg6};
    assign seg_all[1] = {49'b0, seg1};
    assign seg_all[2] = seg8;
    assign ph_all[0]  = ph6;
    assign ph_all[1]  = ph1;
    assign ph_all[2]  = ph8;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int ndig(input int c);
        return (c == 0) ? 6 : ((c == 1) ? 1 : 8);
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    // Display image predicted from the stored value and blanking controls.
    function automatic logic [55:0] model_seg(input int nd, input logic [31:0] sh,
                                              input bit blz, input bit ben, input bit ph,
                                              input logic [7:0] mask);
        logic [55:0] r;
        int hi;
        r  = '0;
        hi = -1;
        for (int k = 0; k < nd; k++) if (sh[4*k +: 4] != 4'h0) hi = k;
        for (int k = 0; k < nd; k++) begin
            if ((blz && k > hi && k != 0) || (ben && ph && mask[k]))
                r[7*k +: 7] = 7'h7F;
            else
                r[7*k +: 7] = glyph(sh[4*k +: 4]);
        end
        return r;
    endfunction

    function automatic logic [55:0] dark(input int nd);
        logic [55:0] r;
        r = '0;
        for (int k = 0; k < 7*nd; k++) r[k] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] trunc(input int nd, input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 4*nd; k++) r[k] = v[k];
        return r;
    endfunction

    // Reference model: blink phase is the parity of completed half-periods in
    // the current run of consecutive enabled cycles.
    always @(posedge clk) begin
        logic [55:0] s;
        bit          ph_old;
        ph_old = m_phase;
        if (!resetn) begin
            m_run   = 0;
            m_phase = 1'b0;
        end else begin
            m_run   = blink_en ? m_run + 1 : 0;
            m_phase = ((m_run / DIV) % 2) == 1;
        end
        for (int c = 0; c < NCFG; c++) begin
            if (!resetn) begin
                s = dark(ndig(c));
                m_shadow[c] = '0;
            end else begin
                s = model_seg(ndig(c), m_shadow[c], blank_lz, blink_en, ph_old, blink_mask);
                if (load) m_shadow[c] = trunc(ndig(c), data);
            end
            exp_q[c].push_back({m_phase, s});
        end
    end

    always @(negedge clk) begin
        logic [56:0] e;
        for (int c = 0; c < NCFG; c++) begin
            if (exp_q[c].size() > 0) begin
                e = exp_q[c].pop_front();
                checks++;
                if (seg_all[c] !== e[55:0]) begin
                    errors++;
                    $display("FAIL seg digits=%0d t=%0t got=%h want=%h", ndig(c), $time,
                             seg_all[c], e[55:0]);
                end
                checks++;
                if (ph_all[c] !== e[56]) begin
                    errors++;
                    $display("FAIL blink_phase digits=%0d t=%0t got=%b want=%b", ndig(c),
                             $time, ph_all[c], e[56]);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int sh;
        m_run      = 0;
        m_phase    = 1'b0;
        for (int c = 0; c < NCFG; c++) m_shadow[c] = '0;
        resetn     = 1'b0;
        load       = 1'b0;
        data       = '0;
        blank_lz   = 1'b0;
        blink_en   = 1'b0;
        blink_mask = '0;
        step(2);
        resetn = 1'b1;
        step(2);
        // Load latency and hold
        data = 32'h000123AF; load = 1'b1; step(1);
        load = 1'b0; step(3);
        // Leading-zero blanking
        blank_lz = 1'b1;
        data = 32'h0000000A; load = 1'b1; step(1);
        load = 1'b0; step(2);
        data = 32'h0; load = 1'b1; step(1);
        load = 1'b0; step(3);
        // Blink on digit 0, then disable
        blank_lz = 1'b0;
        data = 32'h89ABCDEF; load = 1'b1; step(1);
        load = 1'b0;
        blink_mask = 8'h01; blink_en = 1'b1; step(20);
        blink_en = 1'b0; step(3);
        // Back-to-back loads, second on the blink wrap edge
        blink_en = 1'b1; step(2);
        data = 32'h11111111; load = 1'b1; step(1);
        data = 32'h22222222; step(1);
        load = 1'b0; step(6);
        // Reset mid-blink
        resetn = 1'b0; step(1);
        resetn = 1'b1; step(6);
        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            resetn     = ($urandom_range(0, 49) != 0);
            load       = $urandom_range(0, 1) == 1;
            sh         = $urandom_range(0, 32);
            data       = (sh >= 32) ? 32'h0 : ($urandom() >> sh);
            if ($urandom_range(0, 9) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 19) == 0) blink_en = ~blink_en;
            if ($urandom_range(0, 7) == 0) blink_mask = 8'($urandom());
            step(1);
        end
        resetn = 1'b1; load = 1'b0;
        step(3);
        for (int c = 0; c < NCFG; c++) begin
            checks++;
            if (exp_q[c].size() > 1) begin
                errors++;
                $display("FAIL drain digits=%0d got=%0d want<=1", ndig(c), exp_q[c].size());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
